// File: rtl/return_prediction_checker.sv
// Return-address prediction checker: tracks RAS predictions from dispatch
// to JALR resolution, flags mispredictions and squashes younger entries.
module return_prediction_checker #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_WIDTH = 16,
    localparam int unsigned TW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 alloc_valid,
    input  logic [XLEN-1:0]      alloc_target,
    output logic                 alloc_ready,
    output logic [TW-1:0]        alloc_tag,
    input  logic                 resolve_valid,
    input  logic [TW-1:0]        resolve_tag,
    input  logic [XLEN-1:0]      resolve_target,
    output logic                 mispredict,
    output logic [XLEN-1:0]      redirect_pc,
    output logic                 retire_valid,
    output logic [TW:0]          n_entries,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] resolved_q;
    logic [XLEN-1:0]  target_q [DEPTH];
    logic [TW-1:0]    head;
    logic [TW-1:0]    tail;

    logic             full;
    logic             tag_open;
    logic             miss_now;
    logic             resolve_ok;
    logic             squash;
    logic             hit;
    logic             alloc_fire;
    logic             retire_fire;
    logic [TW-1:0]    tag_off;
    logic [TW:0]      n_next;
    logic [DEPTH-1:0] valid_next;
    logic [DEPTH-1:0] resolved_next;

    // Handshake terms and event qualification for this cycle
    always_comb begin
        full        = (n_entries == (TW+1)'(DEPTH));
        tag_open    = valid_q[resolve_tag] && !resolved_q[resolve_tag];
        miss_now    = resolve_valid && tag_open && (resolve_target != target_q[resolve_tag]);
        resolve_ok  = resolve_valid && tag_open && !flush;
        squash      = miss_now && !flush;
        hit         = resolve_ok && !miss_now;
        alloc_ready = !full && !flush && !miss_now;
        alloc_tag   = tail;
        alloc_fire  = alloc_valid && alloc_ready;
        retire_fire = valid_q[head] && resolved_q[head] && !flush;
        tag_off     = TW'(resolve_tag - head);
    end

    // Next occupancy: squash recomputes from the resolved tag, else +alloc -retire
    always_comb begin
        n_next = n_entries + (TW+1)'(alloc_fire) - (TW+1)'(retire_fire);
        if (squash) begin
            n_next = (TW+1)'(tag_off) + (TW+1)'(1) - (TW+1)'(retire_fire);
        end
    end

    // Next entry flags: retire head, mark resolve, squash younger, allocate tail
    always_comb begin
        valid_next    = valid_q;
        resolved_next = resolved_q;
        if (retire_fire) begin
            valid_next[head]    = 1'b0;
            resolved_next[head] = 1'b0;
        end
        if (resolve_ok) begin
            resolved_next[resolve_tag] = 1'b1;
        end
        if (squash) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (TW'(TW'(i) - head) > tag_off) begin
                    valid_next[i]    = 1'b0;
                    resolved_next[i] = 1'b0;
                end
            end
        end
        if (alloc_fire) begin
            valid_next[tail]    = 1'b1;
            resolved_next[tail] = 1'b0;
        end
    end

    // Queue control state, pulses and statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q      <= '0;
            resolved_q   <= '0;
            head         <= '0;
            tail         <= '0;
            n_entries    <= '0;
            mispredict   <= 1'b0;
            retire_valid <= 1'b0;
            redirect_pc  <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else if (flush) begin
            valid_q      <= '0;
            resolved_q   <= '0;
            head         <= '0;
            tail         <= '0;
            n_entries    <= '0;
            mispredict   <= 1'b0;
            retire_valid <= 1'b0;
        end else begin
            valid_q      <= valid_next;
            resolved_q   <= resolved_next;
            n_entries    <= n_next;
            mispredict   <= squash;
            retire_valid <= retire_fire;
            if (retire_fire) begin
                head <= head + TW'(1);
            end
            if (squash) begin
                tail        <= resolve_tag + TW'(1);
                redirect_pc <= resolve_target;
            end else if (alloc_fire) begin
                tail <= tail + TW'(1);
            end
            if (hit && (hit_count != '1)) begin
                hit_count <= hit_count + CNT_WIDTH'(1);
            end
            if (squash && (miss_count != '1)) begin
                miss_count <= miss_count + CNT_WIDTH'(1);
            end
        end
    end

    // Predicted targets are plain datapath storage, written on allocation
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            target_q[tail] <= alloc_target;
        end
    end

endmodule

// File: tb/tb_return_prediction_checker.sv
// Directed bench for return_prediction_checker (DEPTH=8, XLEN=32).
module tb_return_prediction_checker;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        alloc_valid;
    logic [31:0] alloc_target;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        resolve_valid;
    logic [2:0]  resolve_tag;
    logic [31:0] resolve_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        retire_valid;
    logic [3:0]  n_entries;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int tests;
    int failed;

    return_prediction_checker dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .alloc_valid    (alloc_valid),
        .alloc_target   (alloc_target),
        .alloc_ready    (alloc_ready),
        .alloc_tag      (alloc_tag),
        .resolve_valid  (resolve_valid),
        .resolve_tag    (resolve_tag),
        .resolve_target (resolve_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .retire_valid   (retire_valid),
        .n_entries      (n_entries),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush          = 1'b0;
        alloc_valid    = 1'b0;
        alloc_target   = '0;
        resolve_valid  = 1'b0;
        resolve_tag    = '0;
        resolve_target = '0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        step();
        step();
        tests++; if (n_entries !== 4'd0) begin failed++; $display("FAIL reset_n: got %0d expected 0", n_entries); end
        tests++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin failed++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", hit_count, miss_count); end
        tests++; if (mispredict !== 1'b0 || retire_valid !== 1'b0 || redirect_pc !== 32'd0) begin failed++; $display("FAIL reset_pulse: got %b/%b/%h expected 0/0/0", mispredict, retire_valid, redirect_pc); end
        tests++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin failed++; $display("FAIL reset_alloc: got %b/%0d expected 1/0", alloc_ready, alloc_tag); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_alloc();
        for (int k = 0; k < 3; k++) begin
            alloc_valid  = 1'b1;
            alloc_target = 32'h100 * (k + 1);
            #1;
            tests++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'(k)) begin failed++; $display("FAIL alloc_tag%0d: got %b/%0d expected 1/%0d", k, alloc_ready, alloc_tag, k); end
            step();
        end
        idle();
        tests++; if (n_entries !== 4'd3) begin failed++; $display("FAIL alloc_n: got %0d expected 3", n_entries); end
    endtask

    task automatic test_hit_retire();
        resolve_valid  = 1'b1;
        resolve_tag    = 3'd0;
        resolve_target = 32'h100;
        step();
        idle();
        tests++; if (hit_count !== 16'd1 || mispredict !== 1'b0) begin failed++; $display("FAIL hit: got hit=%0d misp=%b expected 1/0", hit_count, mispredict); end
        tests++; if (retire_valid !== 1'b0 || n_entries !== 4'd3) begin failed++; $display("FAIL hit_noretire: got %b/%0d expected 0/3", retire_valid, n_entries); end
        step();
        tests++; if (retire_valid !== 1'b1 || n_entries !== 4'd2) begin failed++; $display("FAIL retire: got %b/%0d expected 1/2", retire_valid, n_entries); end
        step();
        tests++; if (retire_valid !== 1'b0) begin failed++; $display("FAIL retire_pulse: got %b expected 0", retire_valid); end
    endtask

    task automatic test_full();
        do_flush();
        tests++; if (n_entries !== 4'd0 || alloc_tag !== 3'd0) begin failed++; $display("FAIL flush_clear: got %0d/%0d expected 0/0", n_entries, alloc_tag); end
        for (int k = 0; k < 8; k++) begin
            alloc_valid  = 1'b1;
            alloc_target = 32'h1000 + 32'(k);
            step();
        end
        #1;
        tests++; if (n_entries !== 4'd8 || alloc_ready !== 1'b0) begin failed++; $display("FAIL full: got n=%0d rdy=%b expected 8/0", n_entries, alloc_ready); end
        alloc_target = 32'hDEAD;
        step();
        idle();
        tests++; if (n_entries !== 4'd8 || alloc_tag !== 3'd0) begin failed++; $display("FAIL full_drop: got n=%0d tag=%0d expected 8/0", n_entries, alloc_tag); end
    endtask

    task automatic test_mispredict();
        do_flush();
        for (int k = 0; k < 5; k++) begin
            alloc_valid  = 1'b1;
            alloc_target = 32'h100 * (k + 1);
            step();
        end
        idle();
        resolve_valid  = 1'b1;
        resolve_tag    = 3'd2;
        resolve_target = 32'hBEEF;
        alloc_valid    = 1'b1;
        alloc_target   = 32'h777;
        #1;
        tests++; if (alloc_ready !== 1'b0) begin failed++; $display("FAIL miss_block: got %b expected 0", alloc_ready); end
        step();
        idle();
        tests++; if (mispredict !== 1'b1 || redirect_pc !== 32'hBEEF) begin failed++; $display("FAIL miss_pulse: got %b/%h expected 1/0000beef", mispredict, redirect_pc); end
        tests++; if (n_entries !== 4'd3 || alloc_tag !== 3'd3) begin failed++; $display("FAIL miss_squash: got n=%0d tag=%0d expected 3/3", n_entries, alloc_tag); end
        tests++; if (miss_count !== 16'd1 || hit_count !== 16'd1) begin failed++; $display("FAIL miss_cnt: got %0d/%0d expected miss 1 hit 1", miss_count, hit_count); end
        step();
        tests++; if (mispredict !== 1'b0 || redirect_pc !== 32'hBEEF) begin failed++; $display("FAIL miss_hold: got %b/%h expected 0/0000beef", mispredict, redirect_pc); end
        resolve_valid  = 1'b1;
        resolve_tag    = 3'd4;
        resolve_target = 32'h123;
        step();
        idle();
        tests++; if (mispredict !== 1'b0 || miss_count !== 16'd1 || hit_count !== 16'd1 || n_entries !== 4'd3) begin failed++; $display("FAIL stale_tag: got misp=%b miss=%0d hit=%0d n=%0d expected 0/1/1/3", mispredict, miss_count, hit_count, n_entries); end
    endtask

    task automatic test_wrap();
        do_flush();
        for (int k = 0; k < 6; k++) begin
            alloc_valid  = 1'b1;
            alloc_target = 32'hA00 + 32'(k);
            step();
        end
        idle();
        for (int k = 0; k < 6; k++) begin
            resolve_valid  = 1'b1;
            resolve_tag    = 3'(k);
            resolve_target = 32'hA00 + 32'(k);
            step();
        end
        idle();
        step();
        tests++; if (n_entries !== 4'd0 || alloc_tag !== 3'd6 || hit_count !== 16'd7) begin failed++; $display("FAIL wrap_drain: got n=%0d tag=%0d hit=%0d expected 0/6/7", n_entries, alloc_tag, hit_count); end
        for (int k = 0; k < 4; k++) begin
            alloc_valid  = 1'b1;
            alloc_target = 32'hB00 + 32'(k);
            #1;
            tests++; if (alloc_tag !== 3'((6 + k) % 8)) begin failed++; $display("FAIL wrap_tag%0d: got %0d expected %0d", k, alloc_tag, (6 + k) % 8); end
            step();
        end
        idle();
        tests++; if (n_entries !== 4'd4 || alloc_tag !== 3'd2) begin failed++; $display("FAIL wrap_fill: got n=%0d tag=%0d expected 4/2", n_entries, alloc_tag); end
        resolve_valid  = 1'b1;
        resolve_tag    = 3'd7;
        resolve_target = 32'hFFFF;
        step();
        idle();
        tests++; if (mispredict !== 1'b1 || n_entries !== 4'd2 || alloc_tag !== 3'd0) begin failed++; $display("FAIL wrap_miss: got misp=%b n=%0d tag=%0d expected 1/2/0", mispredict, n_entries, alloc_tag); end
        tests++; if (miss_count !== 16'd2 || redirect_pc !== 32'hFFFF) begin failed++; $display("FAIL wrap_cnt: got miss=%0d pc=%h expected 2/0000ffff", miss_count, redirect_pc); end
    endtask

    task automatic test_flush_resolve();
        flush          = 1'b1;
        resolve_valid  = 1'b1;
        resolve_tag    = 3'd6;
        resolve_target = 32'h1;
        step();
        idle();
        tests++; if (n_entries !== 4'd0 || mispredict !== 1'b0 || retire_valid !== 1'b0) begin failed++; $display("FAIL flush_res: got n=%0d misp=%b ret=%b expected 0/0/0", n_entries, mispredict, retire_valid); end
        tests++; if (miss_count !== 16'd2 || hit_count !== 16'd7 || alloc_tag !== 3'd0) begin failed++; $display("FAIL flush_cnt: got miss=%0d hit=%0d tag=%0d expected 2/7/0", miss_count, hit_count, alloc_tag); end
    endtask

    task automatic test_async_reset();
        alloc_valid  = 1'b1;
        alloc_target = 32'h100;
        step();
        idle();
        resolve_valid  = 1'b1;
        resolve_tag    = 3'd0;
        resolve_target = 32'h200;
        step();
        idle();
        tests++; if (mispredict !== 1'b1 || n_entries !== 4'd1) begin failed++; $display("FAIL pre_reset: got misp=%b n=%0d expected 1/1", mispredict, n_entries); end
        #1;
        reset = 1'b0;
        #1;
        tests++; if (mispredict !== 1'b0 || redirect_pc !== 32'd0 || n_entries !== 4'd0) begin failed++; $display("FAIL async_reset: got misp=%b pc=%h n=%0d expected 0/0/0", mispredict, redirect_pc, n_entries); end
        tests++; if (hit_count !== 16'd0 || miss_count !== 16'd0 || retire_valid !== 1'b0) begin failed++; $display("FAIL async_cnt: got %0d/%0d/%b expected 0/0/0", hit_count, miss_count, retire_valid); end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            alloc_valid  = 1'b1;
            alloc_target = 32'h10 * (k + 1);
            step();
        end
        idle();
        resolve_valid  = 1'b1;
        resolve_tag    = 3'd0;
        resolve_target = 32'h10;
        step();
        alloc_valid    = 1'b1;
        alloc_target   = 32'h30;
        resolve_tag    = 3'd1;
        resolve_target = 32'h20;
        step();
        idle();
        tests++; if (retire_valid !== 1'b1 || n_entries !== 4'd2) begin failed++; $display("FAIL b2b_retire: got ret=%b n=%0d expected 1/2", retire_valid, n_entries); end
        tests++; if (hit_count !== 16'd2 || alloc_tag !== 3'd3 || mispredict !== 1'b0) begin failed++; $display("FAIL b2b_state: got hit=%0d tag=%0d misp=%b expected 2/3/0", hit_count, alloc_tag, mispredict); end
        step();
        tests++; if (retire_valid !== 1'b1 || n_entries !== 4'd1) begin failed++; $display("FAIL b2b_retire2: got ret=%b n=%0d expected 1/1", retire_valid, n_entries); end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        reset  = 1'b0;
        idle();
        test_reset();
        test_alloc();
        test_hit_retire();
        test_full();
        test_mispredict();
        test_wrap();
        test_flush_resolve();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/return_prediction_checker.md
Name: return_prediction_checker

Overview:
- Tracks every in-flight return-address prediction produced by the return address stack, from dispatch until resolution.
- When the execute stage resolves a JALR's real target, compares it with the stored prediction. A mismatch produces a redirect and squashes younger tracked predictions.
- Sits between dispatch (writer of predictions) and the branch/JALR execute unit (resolver). Its mispredict output drives the flush that restores the RAS checkpoint.

Parameters:
- XLEN, 32, address width.
- DEPTH, 8, number of tracked predictions; power of two, at least 2. TW = $clog2(DEPTH).
- CNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  external pipeline flush; discards all entries.
- alloc_valid  in  1  dispatch presents a predicted return.
- alloc_target  in  XLEN  predicted target (RAS address_out).
- alloc_ready  out  1  allocation accepted this cycle.
- alloc_tag  out  TW  tag assigned to the allocation (current tail index).
- resolve_valid  in  1  execute reports a resolved JALR.
- resolve_tag  in  TW  tag of the resolved entry.
- resolve_target  in  XLEN  actual computed target.
- mispredict  out  1  registered one-cycle pulse.
- redirect_pc  out  XLEN  correct target; valid when mispredict=1.
- retire_valid  out  1  registered pulse; oldest entry dequeued.
- n_entries  out  TW+1  occupied entries.
- hit_count  out  CNT_WIDTH  correct resolutions, saturating.
- miss_count  out  CNT_WIDTH  mispredicted resolutions, saturating.

Behaviour:
- Reset: clears all entries, head, tail, n_entries and both counters. mispredict, retire_valid and redirect_pc reset to 0. Takes effect immediately, regardless of the clock.
- Entry fields: valid, resolved, target. The queue is circular; head and tail wrap modulo DEPTH.
- full = (n_entries == DEPTH).
- Combinational term: miss_now = resolve_valid && entry[resolve_tag].valid && !entry[resolve_tag].resolved && (resolve_target != entry[resolve_tag].target).
- alloc_ready = !full && !flush && !miss_now. alloc_tag = tail.
- Allocation (alloc_valid && alloc_ready): writes entry[tail] with valid=1, resolved=0, target=alloc_target. tail++ at the edge.
- Resolution is accepted only for a valid, unresolved entry; any other resolve is ignored, with no pulse and no counter change.
  - Accepted resolve: sets resolved=1.
  - Match: hit_count++ (saturating).
  - Mismatch: miss_count++ (saturating).
    - Next cycle: mispredict=1 and redirect_pc=resolve_target. redirect_pc holds its value until the next mispredict.
    - Entries younger than resolve_tag are invalidated.
    - tail <= resolve_tag+1 (mod DEPTH).
    - n_entries <= ((resolve_tag - head) mod DEPTH) + 1, minus 1 if the head retires in the same cycle.
- Retirement: if entry[head].valid && entry[head].resolved before the edge, head is invalidated and head++. retire_valid=1 the next cycle. At most one retirement per cycle. An entry resolved in cycle N retires no earlier than the edge ending cycle N+1.
- n_entries updates by +alloc −retire when no squash occurs.
- flush: highest priority after reset. Invalidates all entries, head=tail=0, n_entries=0, no retire pulse. A resolve in the same cycle is ignored: no mispredict, no counter change.
- Simultaneous events:
  - Allocate plus hit-resolve plus retire in the same cycle are all performed.
  - Mispredict blocks allocation because alloc_ready is low.
  - Only one resolve port exists.
- Tags remain valid until retirement or squash. A stale tag whose entry is invalid is ignored.

Test Plan:
- Reset, then allocate targets 0x100, 0x200, 0x300 → tags 0, 1, 2; n_entries=3; alloc_ready=1 throughout.
- Resolve tag 0 with 0x100 → hit_count=1, no mispredict. Next edge: retire_valid=1, n_entries=2.
- Allocate 8 entries (DEPTH=8) → alloc_ready=0 when n_entries=8. A further alloc_valid is dropped and tail stays at 0.
- With tags 0–4 allocated, resolve tag 2 with 0xBEEF against stored 0x300:
  - Next cycle: mispredict=1, redirect_pc=0xBEEF.
  - tags 3 and 4 are invalidated; n_entries=3; alloc_tag=3; miss_count=1.
  - A later resolve of tag 4 is ignored.
- Wrap-around: head=6 and tail=2 (n_entries=4). A mispredict on tag 7 → n_entries=2, tail=0.
- Assert flush with a simultaneous mismatching resolve → n_entries=0, mispredict stays 0, miss_count unchanged. Assert reset mid-stream → all outputs 0 immediately.
